// File: rtl/iserdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iserdes_pkg
//  Description : Shared constants and FSM state type for the SDR input
//                deserializer and its bitslip controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package iserdes_pkg;

    // Widest word the deserializer can assemble (Q1..Q6)
    localparam int MAX_DATA_WIDTH = 6;

    // Width of the bit counter and the guard counter (holds 0..MAX_DATA_WIDTH-1)
    localparam int CNT_WIDTH = 3;

    // Bitslip controller states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } slip_state_e;

endpackage
`default_nettype wire

// File: rtl/iserdes_bitslip_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : iserdes_bitslip_fsm
//  Description : Accepts BITSLIP requests and blanks further requests for one
//                word time (DATA_WIDTH clocks including the accepting edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module iserdes_bitslip_fsm
    import iserdes_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic CLK,
    input  logic SR,
    input  logic CE,
    input  logic BITSLIP,
    output logic slip_accept,
    output logic SLIPACK
);

    localparam logic [CNT_WIDTH-1:0] c_GUARD_LOAD = CNT_WIDTH'(DATA_WIDTH - 1);

    slip_state_e           r_state;
    logic [CNT_WIDTH-1:0]  r_guard_cnt;
    logic                  r_slipack;

    // A request only counts on a CE-qualified edge while the guard is idle
    assign slip_accept = CE && BITSLIP && (r_state == ST_RUN);
    assign SLIPACK     = r_slipack;

    // RUN/GUARD sequencing; the guard counts every clock, independent of CE
    always_ff @(posedge CLK) begin
        if (SR) begin
            r_state     <= ST_RUN;
            r_guard_cnt <= '0;
            r_slipack   <= 1'b0;
        end else begin
            r_slipack <= slip_accept;
            case (r_state)
                ST_RUN: begin
                    if (slip_accept) begin
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= c_GUARD_LOAD;
                    end
                end
                ST_GUARD: begin
                    r_guard_cnt <= r_guard_cnt - 1'b1;
                    if (r_guard_cnt == CNT_WIDTH'(1)) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_guard_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iserdes_sdr.sv
`default_nettype none
// ============================================================================
//  Module      : iserdes_sdr
//  Description : Single-clock SDR input deserializer. Shifts one bit per
//                CE-qualified clock, presents DATA_WIDTH-bit words on Q1..Q6
//                (Q1 = first-received bit) with a one-cycle QVALID strobe, and
//                moves the word boundary one bit later on an accepted BITSLIP.
//  Revision    : 1.0 - initial release
// ============================================================================
module iserdes_sdr
    import iserdes_pkg::*;
#(
    parameter int   DATA_WIDTH = 4,
    parameter logic SRVAL_Q    = 1'b0
) (
    input  logic CLK,
    input  logic SR,
    input  logic CE,
    input  logic D,
    input  logic BITSLIP,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic QVALID,
    output logic SLIPACK
);

    // Reject unsupported word widths at elaboration
    if (DATA_WIDTH < 2 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("iserdes_sdr: DATA_WIDTH must be within 2..6");
    end

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic                      w_slip_accept;
    logic                      w_capture;
    logic [DATA_WIDTH-1:0]     w_word;
    logic [DATA_WIDTH-2:0]     r_shift;
    logic [DATA_WIDTH-1:0]     r_word;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      r_qvalid;
    logic [MAX_DATA_WIDTH-1:0] w_q;

    iserdes_bitslip_fsm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bitslip_fsm (
        .CLK         (CLK),
        .SR          (SR),
        .CE          (CE),
        .BITSLIP     (BITSLIP),
        .slip_accept (w_slip_accept),
        .SLIPACK     (SLIPACK)
    );

    // Only DATA_WIDTH-1 history bits are needed: the current D completes the word
    assign w_word    = {r_shift, D};
    assign w_capture = CE && !w_slip_accept && (r_cnt == c_CNT_LAST);

    // Shift register, bit counter and word capture; a slip freezes the counter
    always_ff @(posedge CLK) begin
        if (SR) begin
            r_shift  <= {(DATA_WIDTH-1){SRVAL_Q}};
            r_word   <= {DATA_WIDTH{SRVAL_Q}};
            r_cnt    <= '0;
            r_qvalid <= 1'b0;
        end else begin
            r_qvalid <= w_capture;
            if (CE) begin
                r_shift <= w_word[DATA_WIDTH-2:0];
                if (!w_slip_accept) begin
                    r_cnt <= w_capture ? '0 : r_cnt + 1'b1;
                end
            end
            if (w_capture) begin
                r_word <= w_word;
            end
        end
    end

    // Oldest bit of the captured word drives Q1; unused outputs sit at SRVAL_Q
    for (genvar i = 0; i < MAX_DATA_WIDTH; i++) begin : g_q
        if (i < DATA_WIDTH) begin : g_used
            assign w_q[i] = r_word[DATA_WIDTH-1-i];
        end else begin : g_tied
            assign w_q[i] = SRVAL_Q;
        end
    end

    assign Q1     = w_q[0];
    assign Q2     = w_q[1];
    assign Q3     = w_q[2];
    assign Q4     = w_q[3];
    assign Q5     = w_q[4];
    assign Q6     = w_q[5];
    assign QVALID = r_qvalid;

endmodule
`default_nettype wire
